// File: rtl/writeback_commit.sv
// Writeback/commit stage: holds one execute result, presents it to the
// register-file write port, feeds the bypass pair back to execute and counts
// retired entries.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | out of reset, nothing accepted until startSig
//   WAIT_BEF | hold empty, waiting for execute to send a result
//   COMMIT   | hold entry presented to the register file until it retires
module writeback_commit #(
   parameter int XLEN    = 32,
   parameter int REG_IDX = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               startSig,
   input  logic               beforePipReadyToSend,
   input  logic               in_valid,
   input  logic [REG_IDX-1:0] in_idx,
   input  logic [XLEN-1:0]    in_val,
   output logic               curPipReadyToRcv,
   output logic               regFile_writeEn,
   output logic [REG_IDX-1:0] regFile_writeIdx,
   output logic [XLEN-1:0]    regFile_writeData,
   input  logic               regFile_writeReady,
   output logic [REG_IDX-1:0] bp_idx,
   output logic [XLEN-1:0]    bp_val,
   output logic [CNT_W-1:0]   retireCount,
   output logic               busy
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_BEF = 2'd1;
   localparam logic [1:0] COMMIT   = 2'd2;

   logic [1:0]         state_q, state_d;
   logic               h_valid_q, h_valid_d;
   logic [REG_IDX-1:0] h_idx_q, h_idx_d;
   logic [XLEN-1:0]    h_val_q, h_val_d;
   logic [REG_IDX-1:0] cb_idx_q, cb_idx_d;
   logic [XLEN-1:0]    cb_val_q, cb_val_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic in_commit;
   logic need_wr;
   logic done;
   logic rcv;
   logic accept;
   logic capture;

   // Handshake decode; every output is forced quiet while reset is asserted so
   // a pending write cannot slip out in the reset cycle.
   always_comb begin
      in_commit = (state_q == COMMIT) & ~rst;
      need_wr   = h_valid_q & (h_idx_q != '0);
      done      = in_commit & (~need_wr | regFile_writeReady);
      rcv       = ((state_q == WAIT_BEF) & ~rst) | done;
      accept    = rcv & beforePipReadyToSend & ~startSig;
      capture   = accept | (startSig & beforePipReadyToSend);
   end

   // Next-state, hold capture, committed-bypass and retire counter updates.
   always_comb begin
      state_d   = state_q;
      h_valid_d = h_valid_q;
      h_idx_d   = h_idx_q;
      h_val_d   = h_val_q;
      cb_idx_d  = cb_idx_q;
      cb_val_d  = cb_val_q;
      cnt_d     = cnt_q;

      if (startSig) begin
         state_d = beforePipReadyToSend ? COMMIT : WAIT_BEF;
      end else begin
         case (state_q)
            IDLE:     state_d = IDLE;
            WAIT_BEF: state_d = accept ? COMMIT : WAIT_BEF;
            COMMIT:   begin
               if (done && !accept) state_d = WAIT_BEF;
               else                 state_d = COMMIT;
            end
            default:  state_d = IDLE;
         endcase
      end

      if (capture) begin
         h_valid_d = in_valid;
         h_idx_d   = in_idx;
         h_val_d   = in_val;
      end

      if (done) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (need_wr) begin
            cb_idx_d = h_idx_q;
            cb_val_d = h_val_q;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         h_valid_q <= 1'b0;
         h_idx_q   <= '0;
         h_val_q   <= '0;
         cb_idx_q  <= '0;
         cb_val_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         h_valid_q <= h_valid_d;
         h_idx_q   <= h_idx_d;
         h_val_q   <= h_val_d;
         cb_idx_q  <= cb_idx_d;
         cb_val_q  <= cb_val_d;
         cnt_q     <= cnt_d;
      end
   end

   // Output drive: the live hold entry wins the bypass while it is being written.
   always_comb begin
      curPipReadyToRcv  = rcv;
      regFile_writeEn   = in_commit & need_wr;
      regFile_writeIdx  = regFile_writeEn ? h_idx_q : '0;
      regFile_writeData = regFile_writeEn ? h_val_q : '0;
      if (rst) begin
         bp_idx = '0;
         bp_val = '0;
      end else if (regFile_writeEn) begin
         bp_idx = h_idx_q;
         bp_val = h_val_q;
      end else begin
         bp_idx = cb_idx_q;
         bp_val = cb_val_q;
      end
      retireCount = rst ? '0 : cnt_q;
      busy        = in_commit;
   end

endmodule

// File: tb/tb_writeback_commit.sv
// Directed bench for writeback_commit: a per-cycle vector table plus a
// hand-written streaming/wrap sequence. A second instance with a 4-bit
// retire counter runs on the same stimulus to exercise counter wrap.
module tb_writeback_commit;

   logic        clk = 1'b0;
   logic        rst, startSig, bpts, in_valid, wr_ready;
   logic [4:0]  in_idx;
   logic [31:0] in_val;

   logic        rcv, we, busy;
   logic [4:0]  widx, bpi;
   logic [31:0] wdata, bpv, cnt;

   logic        rcv4, we4, busy4;
   logic [4:0]  widx4, bpi4;
   logic [31:0] wdata4, bpv4;
   logic [3:0]  cnt4;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   writeback_commit #(.XLEN(32), .REG_IDX(5), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .startSig(startSig), .beforePipReadyToSend(bpts),
      .in_valid(in_valid), .in_idx(in_idx), .in_val(in_val),
      .curPipReadyToRcv(rcv), .regFile_writeEn(we), .regFile_writeIdx(widx),
      .regFile_writeData(wdata), .regFile_writeReady(wr_ready),
      .bp_idx(bpi), .bp_val(bpv), .retireCount(cnt), .busy(busy));

   writeback_commit #(.XLEN(32), .REG_IDX(5), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .startSig(startSig), .beforePipReadyToSend(bpts),
      .in_valid(in_valid), .in_idx(in_idx), .in_val(in_val),
      .curPipReadyToRcv(rcv4), .regFile_writeEn(we4), .regFile_writeIdx(widx4),
      .regFile_writeData(wdata4), .regFile_writeReady(wr_ready),
      .bp_idx(bpi4), .bp_val(bpv4), .retireCount(cnt4), .busy(busy4));

   typedef struct {
      logic        rst, st, bs, v;
      logic [4:0]  idx;
      logic [31:0] val;
      logic        rdy;
      logic        e_rcv, e_we;
      logic [4:0]  e_widx;
      logic [31:0] e_wdata;
      logic [4:0]  e_bpi;
      logic [31:0] e_bpv;
      logic [31:0] e_cnt;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic r, logic s, logic b, logic v, logic [4:0] i,
                               logic [31:0] d, logic y, logic erc, logic ewe,
                               logic [4:0] ewi, logic [31:0] ewd, logic [4:0] ebi,
                               logic [31:0] ebv, logic [31:0] ec, logic eb);
      vec_t t;
      t.rst = r; t.st = s; t.bs = b; t.v = v; t.idx = i; t.val = d; t.rdy = y;
      t.e_rcv = erc; t.e_we = ewe; t.e_widx = ewi; t.e_wdata = ewd;
      t.e_bpi = ebi; t.e_bpv = ebv; t.e_cnt = ec; t.e_busy = eb;
      return t;
   endfunction

   task automatic check(input string name, input int cyc, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   task automatic drive(input logic r, input logic s, input logic b, input logic v,
                        input logic [4:0] i, input logic [31:0] d, input logic y);
      rst = r; startSig = s; bpts = b; in_valid = v; in_idx = i; in_val = d;
      wr_ready = y;
   endtask

   initial begin
      drive(1, 0, 0, 0, 5'd0, 32'h0, 0);

      //            rst st bs v idx  val           rdy | rcv we widx wdata        bpi  bpv           cnt busy
      // reset
      vecs.push_back(mk(1,0,0,0,5'd0,32'h0,        0,  0,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      vecs.push_back(mk(1,0,0,0,5'd0,32'h0,        0,  0,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      // idle ignores a send without start
      vecs.push_back(mk(0,0,1,1,5'd3,32'h3,        1,  0,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      // 1: start + send x5
      vecs.push_back(mk(0,1,1,1,5'd5,32'hDEADBEEF, 1,  0,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,1,5'd5,32'hDEADBEEF, 5'd5,32'hDEADBEEF, 0,1));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,0,5'd0,32'h0,        5'd5,32'hDEADBEEF, 1,0));
      // 2: write to x0 never issued, still counted
      vecs.push_back(mk(0,0,1,1,5'd0,32'h1234,     1,  1,0,5'd0,32'h0,        5'd5,32'hDEADBEEF, 1,0));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,0,5'd0,32'h0,        5'd5,32'hDEADBEEF, 1,1));
      // 3: x7 stalled 3 cycles; an offer during the stall is not taken
      vecs.push_back(mk(0,0,1,1,5'd7,32'h55,       0,  1,0,5'd0,32'h0,        5'd5,32'hDEADBEEF, 2,0));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        0,  0,1,5'd7,32'h55,       5'd7,32'h55,       2,1));
      vecs.push_back(mk(0,0,1,1,5'd8,32'h66,       0,  0,1,5'd7,32'h55,       5'd7,32'h55,       2,1));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        0,  0,1,5'd7,32'h55,       5'd7,32'h55,       2,1));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,1,5'd7,32'h55,       5'd7,32'h55,       2,1));
      // 4: four back-to-back results
      vecs.push_back(mk(0,0,1,1,5'd1,32'h11,       1,  1,0,5'd0,32'h0,        5'd7,32'h55,       3,0));
      vecs.push_back(mk(0,0,1,1,5'd2,32'h22,       1,  1,1,5'd1,32'h11,       5'd1,32'h11,       3,1));
      vecs.push_back(mk(0,0,1,1,5'd3,32'h33,       1,  1,1,5'd2,32'h22,       5'd2,32'h22,       4,1));
      vecs.push_back(mk(0,0,1,1,5'd4,32'h44,       1,  1,1,5'd3,32'h33,       5'd3,32'h33,       5,1));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,1,5'd4,32'h44,       5'd4,32'h44,       6,1));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,0,5'd0,32'h0,        5'd4,32'h44,       7,0));
      // 5: reset during stalled x9 commit
      vecs.push_back(mk(0,0,1,1,5'd9,32'h99,       0,  1,0,5'd0,32'h0,        5'd4,32'h44,       7,0));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        0,  0,1,5'd9,32'h99,       5'd9,32'h99,       7,1));
      vecs.push_back(mk(1,0,0,0,5'd0,32'h0,        1,  0,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  0,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      // 6b: start during stalled commit discards the entry
      vecs.push_back(mk(0,1,1,1,5'd10,32'hA0,      0,  0,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        0,  0,1,5'd10,32'hA0,      5'd10,32'hA0,      0,1));
      vecs.push_back(mk(0,1,0,0,5'd0,32'h0,        0,  0,1,5'd10,32'hA0,      5'd10,32'hA0,      0,1));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      // start with a send from WAIT_BEF captures directly
      vecs.push_back(mk(0,1,1,1,5'd11,32'hB0,      1,  1,0,5'd0,32'h0,        5'd0,32'h0,        0,0));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,1,5'd11,32'hB0,      5'd11,32'hB0,      0,1));
      vecs.push_back(mk(0,0,0,0,5'd0,32'h0,        1,  1,0,5'd0,32'h0,        5'd11,32'hB0,      1,0));

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].rst, vecs[k].st, vecs[k].bs, vecs[k].v, vecs[k].idx,
               vecs[k].val, vecs[k].rdy);
         #1;
         check("rcv",   k, {31'd0, rcv},  {31'd0, vecs[k].e_rcv});
         check("we",    k, {31'd0, we},   {31'd0, vecs[k].e_we});
         check("widx",  k, {27'd0, widx}, {27'd0, vecs[k].e_widx});
         check("wdata", k, wdata,         vecs[k].e_wdata);
         check("bpi",   k, {27'd0, bpi},  {27'd0, vecs[k].e_bpi});
         check("bpv",   k, bpv,           vecs[k].e_bpv);
         check("cnt",   k, cnt,           vecs[k].e_cnt);
         check("busy",  k, {31'd0, busy}, {31'd0, vecs[k].e_busy});
         check("cnt4",  k, {28'd0, cnt4}, {28'd0, vecs[k].e_cnt[3:0]});
      end

      // Streaming wrap: reset, then 17 entries one per cycle.
      @(negedge clk);
      drive(1, 0, 0, 0, 5'd0, 32'h0, 1);
      @(negedge clk);
      drive(0, 1, 1, 1, 5'd1, 32'h1000, 1);
      #1;
      check("wrap_idle_we", 100, {31'd0, we}, 32'd0);
      for (int k = 1; k <= 17; k++) begin
         @(negedge clk);
         if (k < 17) drive(0, 0, 1, 1, 5'(k + 1), 32'h1000 + 32'(k), 1);
         else        drive(0, 0, 0, 0, 5'd0, 32'h0, 1);
         #1;
         check("wrap_we",   100 + k, {31'd0, we},   32'd1);
         check("wrap_widx", 100 + k, {27'd0, widx}, 32'(k));
         check("wrap_data", 100 + k, wdata,         32'h1000 + 32'(k - 1));
         check("wrap_cnt",  100 + k, cnt,           32'(k - 1));
      end
      @(negedge clk);
      drive(0, 0, 0, 0, 5'd0, 32'h0, 1);
      #1;
      check("wrap_cnt32", 200, cnt, 32'd17);
      check("wrap_cnt4",  200, {28'd0, cnt4}, 32'd1);
      check("wrap_busy",  200, {31'd0, busy}, 32'd0);
      check("wrap_rcv",   200, {31'd0, rcv}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
